// File: rtl/masked_pkg.sv
// Shared helpers for the Boolean-masked arithmetic datapath.
package masked_pkg;

  // Fresh random bits consumed by one HPC2 AND gadget with nshares shares.
  function automatic int unsigned hpc2_nrnd(input int unsigned nshares);
    return nshares * (nshares - 1) / 2;
  endfunction

  // Pipeline latency of the W-bit masked adder: input reg, 2 cycles per carry stage, output reg.
  function automatic int unsigned adder_latency(input int unsigned width);
    return 2 * width + 2;
  endfunction

  // Total randomness width of the W-bit adder: 2W-1 gadgets.
  function automatic int unsigned adder_rnd_w(input int unsigned nshares, input int unsigned width);
    return (2 * width - 1) * hpc2_nrnd(nshares);
  endfunction

  // Index of the random bit shared by share pair {i, j} inside one gadget's slice.
  function automatic int unsigned pair_idx(input int unsigned i, input int unsigned j,
                                           input int unsigned nshares);
    int unsigned lo;
    int unsigned hi;
    if (i == j) return 0;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * nshares - lo * (lo + 1) / 2 + (hi - lo - 1);
  endfunction

endpackage

// File: rtl/masked_carry_stage.sv
// One carry slice (bit BIT >= 1): c_out = g ^ (p & c_in), sum = p ^ c_in.
// p arrives at stage 1, g at stage 3, c_in at stage 1+2*BIT; sum leaves at stage 1+2W.
module masked_carry_stage
  import masked_pkg::*;
#(
  parameter int unsigned d   = 2,
  parameter int unsigned W   = 4,
  parameter int unsigned BIT = 1
) (
  input  logic                    clk,
  input  logic [d-1:0]            p_in,
  input  logic [d-1:0]            g_in,
  input  logic [d-1:0]            c_in,
  input  logic [hpc2_nrnd(d)-1:0] rnd,
  output logic [d-1:0]            c_out,
  output logic [d-1:0]            s_out
);
  localparam int unsigned SKEW    = 2 * BIT;
  localparam int unsigned SUM_DLY = 2 * (W - BIT);

  logic [d-1:0] p_sk;
  logic [d-1:0] g_sk;
  logic [d-1:0] pc;
  logic [d-1:0] s_now;

  // Align propagate and generate with this bit's incoming carry
  masked_skew #(.N(d), .DEPTH(SKEW)) u_p_skew (.clk(clk), .din(p_in), .dout(p_sk));
  masked_skew #(.N(d), .DEPTH(SKEW)) u_g_skew (.clk(clk), .din(g_in), .dout(g_sk));

  // g and p&c are never both 1, so XOR stands in for OR
  MSKand_HPC2 #(.d(d)) u_pc (.clk(clk), .ina(p_sk), .inb(c_in), .rnd(rnd), .out(pc));
  MSKxor #(.d(d)) u_carry (.ina(g_sk), .inb(pc), .out(c_out));

  // Sum bit, held until the final carry is ready
  MSKxor #(.d(d)) u_sum (.ina(p_sk), .inb(c_in), .out(s_now));
  masked_skew #(.N(d), .DEPTH(SUM_DLY)) u_s_skew (.clk(clk), .din(s_now), .dout(s_out));
endmodule

// File: rtl/masked_gadgets.sv
// Masking gadget library: share register, share-wise XOR, HPC2 AND, share skew line.

// One register stage over a bundle of shares; deliberately unreset.
module MSKreg #(
  parameter int unsigned d = 2
) (
  input  logic         clk,
  input  logic [d-1:0] din,
  output logic [d-1:0] dout
);
  // Plain share register
  always_ff @(posedge clk) begin
    dout <= din;
  end
endmodule

// Share-wise XOR of two masked values.
module MSKxor #(
  parameter int unsigned d = 2
) (
  input  logic [d-1:0] ina,
  input  logic [d-1:0] inb,
  output logic [d-1:0] out
);
  assign out = ina ^ inb;
endmodule

// HPC2 masked AND, two-cycle latency; inputs and rnd are consumed in the first cycle.
module MSKand_HPC2
  import masked_pkg::*;
#(
  parameter int unsigned d = 2
) (
  input  logic                    clk,
  input  logic [d-1:0]            ina,
  input  logic [d-1:0]            inb,
  input  logic [hpc2_nrnd(d)-1:0] rnd,
  output logic [d-1:0]            out
);
  logic [d-1:0]         a_q;
  logic [d-1:0]         ab_q;
  logic [d-1:0]         acc;
  logic [d-1:0][d-1:0]  u_q;
  logic [d-1:0][d-1:0]  v_q;

  // First layer: own-share product plus blinded cross terms, diagonal kept at zero
  always_ff @(posedge clk) begin
    a_q  <= ina;
    ab_q <= ina & inb;
    for (int unsigned i = 0; i < d; i++) begin
      for (int unsigned j = 0; j < d; j++) begin
        if (i == j) begin
          u_q[i][j] <= 1'b0;
          v_q[i][j] <= 1'b0;
        end else begin
          u_q[i][j] <= ~ina[i] & rnd[pair_idx(i, j, d)];
          v_q[i][j] <= inb[j] ^ rnd[pair_idx(i, j, d)];
        end
      end
    end
  end

  // Compress cross terms per output share; the random bits cancel pairwise
  always_comb begin
    acc = ab_q;
    for (int unsigned i = 0; i < d; i++) begin
      for (int unsigned j = 0; j < d; j++) begin
        acc[i] = acc[i] ^ u_q[i][j] ^ (a_q[i] & v_q[i][j]);
      end
    end
  end

  // Second layer: output register
  always_ff @(posedge clk) begin
    out <= acc;
  end
endmodule

// DEPTH-stage share delay line (DEPTH >= 1).
module masked_skew #(
  parameter int unsigned N     = 2,
  parameter int unsigned DEPTH = 1
) (
  input  logic         clk,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout
);
  logic [N-1:0] tap [DEPTH+1];

  assign tap[0] = din;
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    MSKreg #(.d(N)) u_reg (.clk(clk), .din(tap[k]), .dout(tap[k+1]));
  end
  assign dout = tap[DEPTH];
endmodule

// File: rtl/masked_adder_nbit.sv
// Pipelined Boolean-masked W-bit ripple-carry adder/subtractor with d shares (HPC2 gadgets).
module masked_adder_nbit
  import masked_pkg::*;
#(
  parameter int unsigned d = 2,
  parameter int unsigned W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic                       in_sub,
  input  logic [W*d-1:0]             in_a,
  input  logic [W*d-1:0]             in_b,
  input  logic [adder_rnd_w(d,W)-1:0] rnd,
  output logic                       out_valid,
  output logic [(W+1)*d-1:0]         out_c
);
  localparam int unsigned L  = adder_latency(W);
  localparam int unsigned NR = hpc2_nrnd(d);
  localparam int unsigned DW = W * d;

  logic [DW-1:0]        a_r;
  logic [DW-1:0]        b_r;
  logic                 sub_r;
  logic [L-1:0]         vld_sr;
  logic [d-1:0]         sub_sh;
  logic [d-1:0]         p [W];
  logic [d-1:0]         g [W];
  logic [d-1:0]         s [W];
  logic [d-1:0]         c [1:W];
  logic [d-1:0]         pc0;
  logic [d-1:0]         pc0_d;
  logic [d-1:0]         s0_now;
  logic [(W+1)*d-1:0]   res_d;

  // Input share registers (unreset)
  MSKreg #(.d(DW)) u_a_reg (.clk(clk), .din(in_a), .dout(a_r));
  MSKreg #(.d(DW)) u_b_reg (.clk(clk), .din(in_b), .dout(b_r));

  // Control pipeline: public sub flag for stage 1, valid shifted alongside the data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_r  <= 1'b0;
      vld_sr <= '0;
    end else begin
      sub_r  <= in_sub;
      vld_sr <= {vld_sr[L-2:0], in_valid};
    end
  end

  assign out_valid = vld_sr[L-1];

  // Public sub bit as a masked constant: only share 0 carries it
  assign sub_sh = {{(d-1){1'b0}}, sub_r};

  // Per-bit propagate and generate; b is complemented through share 0 in sub mode
  for (genvar i = 0; i < W; i++) begin : g_bit
    logic [d-1:0] b_eff;
    assign b_eff = b_r[i*d +: d] ^ sub_sh;
    MSKxor #(.d(d)) u_p (.ina(a_r[i*d +: d]), .inb(b_eff), .out(p[i]));
    MSKand_HPC2 #(.d(d)) u_g (
      .clk(clk), .ina(a_r[i*d +: d]), .inb(b_eff), .rnd(rnd[i*NR +: NR]), .out(g[i])
    );
  end

  // Bit 0: carry-in is public, so p0 & c0 is a share-wise mask and needs no gadget
  assign pc0 = p[0] & {d{sub_r}};
  masked_skew #(.N(d), .DEPTH(2)) u_pc0_skew (.clk(clk), .din(pc0), .dout(pc0_d));
  MSKxor #(.d(d)) u_c1 (.ina(g[0]), .inb(pc0_d), .out(c[1]));
  assign s0_now = p[0] ^ sub_sh;
  masked_skew #(.N(d), .DEPTH(2*W)) u_s0_skew (.clk(clk), .din(s0_now), .dout(s[0]));

  // Ripple chain for bits 1..W-1
  for (genvar i = 1; i < W; i++) begin : g_carry
    masked_carry_stage #(.d(d), .W(W), .BIT(i)) u_stage (
      .clk  (clk),
      .p_in (p[i]),
      .g_in (g[i]),
      .c_in (c[i]),
      .rnd  (rnd[(W+i-1)*NR +: NR]),
      .c_out(c[i+1]),
      .s_out(s[i])
    );
  end

  // Gather sum bits and carry-out into the output layout
  for (genvar i = 0; i < W; i++) begin : g_pack
    assign res_d[i*d +: d] = s[i];
  end
  assign res_d[W*d +: d] = c[W];

  MSKreg #(.d((W+1)*d)) u_out_reg (.clk(clk), .din(res_d), .dout(out_c));
endmodule

// File: tb/tb_masked_adder_nbit.sv
// Bench for masked_adder_nbit: three configurations (d=2/W=4, d=3/W=4, d=2/W=1) run side by side.
module tb_masked_adder_nbit;

  typedef struct {
    int unsigned due;
    int unsigned val;
  } ent_t;

  logic clk;
  logic rst_n;

  logic        v0, sb0, ov0;
  logic [7:0]  a0, b0;
  logic [6:0]  r0;
  logic [9:0]  oc0;

  logic        v1, sb1, ov1;
  logic [11:0] a1, b1;
  logic [20:0] r1;
  logic [14:0] oc1;

  logic        v2, sb2, ov2;
  logic [1:0]  a2, b2;
  logic [0:0]  r2;
  logic [3:0]  oc2;

  int unsigned cyc;
  int          total;
  int          bad;
  ent_t        q0[$];
  ent_t        q1[$];
  ent_t        q2[$];

  masked_adder_nbit #(.d(2), .W(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_sub(sb0), .in_a(a0), .in_b(b0),
    .rnd(r0), .out_valid(ov0), .out_c(oc0)
  );
  masked_adder_nbit #(.d(3), .W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_sub(sb1), .in_a(a1), .in_b(b1),
    .rnd(r1), .out_valid(ov1), .out_c(oc1)
  );
  masked_adder_nbit #(.d(2), .W(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_sub(sb2), .in_a(a2), .in_b(b2),
    .rnd(r2), .out_valid(ov2), .out_c(oc2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain integer add / subtract with borrow-free flag in bit w
  function automatic int unsigned ref_add(input int unsigned a, input int unsigned b,
                                          input bit sub, input int unsigned w);
    int unsigned lim;
    lim = 1 << w;
    if (sub) return ((a >= b) ? lim : 0) + ((a + lim - b) % lim);
    return a + b;
  endfunction

  // Split each bit of v into nd random shares
  function automatic logic [63:0] mask_val(input int unsigned v, input int unsigned w,
                                           input int unsigned nd);
    logic [63:0] m;
    logic        acc;
    m = '0;
    for (int unsigned i = 0; i < w; i++) begin
      acc = v[i];
      for (int unsigned k = 1; k < nd; k++) begin
        m[i*nd+k] = 1'($urandom);
        acc = acc ^ m[i*nd+k];
      end
      m[i*nd] = acc;
    end
    return m;
  endfunction

  function automatic logic [31:0] unmask(input logic [63:0] x, input int unsigned nbits,
                                         input int unsigned nd);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < nbits; i++)
      for (int unsigned k = 0; k < nd; k++)
        r[i] = r[i] ^ x[i*nd+k];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic drive(input int unsigned k, input bit sub, input int unsigned a,
                       input int unsigned b);
    logic [63:0] ma, mb;
    ent_t        e;
    int unsigned w, nd, lat;
    case (k)
      0:       begin w = 4; nd = 2; lat = 10; end
      1:       begin w = 4; nd = 3; lat = 10; end
      default: begin w = 1; nd = 2; lat = 4;  end
    endcase
    ma    = mask_val(a, w, nd);
    mb    = mask_val(b, w, nd);
    e.due = cyc + lat;
    e.val = ref_add(a, b, sub, w);
    case (k)
      0:       begin v0 = 1'b1; sb0 = sub; a0 = ma[7:0];  b0 = mb[7:0];  q0.push_back(e); end
      1:       begin v1 = 1'b1; sb1 = sub; a1 = ma[11:0]; b1 = mb[11:0]; q1.push_back(e); end
      default: begin v2 = 1'b1; sb2 = sub; a2 = ma[1:0];  b2 = mb[1:0];  q2.push_back(e); end
    endcase
  endtask

  task automatic drive_rand(input int unsigned k);
    int unsigned top;
    top = (k == 2) ? 1 : 15;
    drive(k, 1'($urandom_range(0, 1)), $urandom_range(0, top), $urandom_range(0, top));
  endtask

  task automatic lane_check(input int unsigned k);
    ent_t        e;
    bit          has;
    logic        ov;
    logic [63:0] oc;
    int unsigned w, nd;
    has   = 1'b0;
    e.due = 0;
    e.val = 0;
    case (k)
      0: begin
        ov = ov0; oc = 64'(oc0); w = 4; nd = 2;
        if (q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); has = 1'b1; end
      end
      1: begin
        ov = ov1; oc = 64'(oc1); w = 4; nd = 3;
        if (q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); has = 1'b1; end
      end
      default: begin
        ov = ov2; oc = 64'(oc2); w = 1; nd = 2;
        if (q2.size() > 0 && q2[0].due == cyc) begin e = q2.pop_front(); has = 1'b1; end
      end
    endcase
    chk($sformatf("lane%0d_out_valid", k), 32'(ov), 32'(has));
    if (has) chk($sformatf("lane%0d_result", k), unmask(oc, w + 1, nd), e.val);
  endtask

  // One clock: sample outputs just after the edge, then idle inputs with fresh junk
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int unsigned k = 0; k < 3; k++) lane_check(k);
    v0 = 1'b0; sb0 = 1'($urandom); a0 = 8'($urandom);  b0 = 8'($urandom);  r0 = 7'($urandom);
    v1 = 1'b0; sb1 = 1'($urandom); a1 = 12'($urandom); b1 = 12'($urandom); r1 = 21'($urandom);
    v2 = 1'b0; sb2 = 1'($urandom); a2 = 2'($urandom);  b2 = 2'($urandom);  r2 = 1'($urandom);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    v0 = 1'b0; sb0 = 1'b0; a0 = '0; b0 = '0; r0 = '0;
    v1 = 1'b0; sb1 = 1'b0; a1 = '0; b1 = '0; r1 = '0;
    v2 = 1'b0; sb2 = 1'b0; a2 = '0; b2 = '0; r2 = '0;
    rst_n = 1'b1;

    // Reset state: async clear, then held through a few edges
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_lane0", 32'(ov0), 32'd0);
    chk("rst_async_lane1", 32'(ov1), 32'd0);
    chk("rst_async_lane2", 32'(ov2), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Directed operands from the spec examples
    drive(0, 1'b0, 3, 5);   drive(1, 1'b1, 7, 5); drive(2, 1'b0, 1, 1); tick();
    drive(0, 1'b0, 15, 1);  drive(1, 1'b1, 5, 7); drive(2, 1'b1, 0, 1); tick();
    drive(0, 1'b0, 15, 15); drive(1, 1'b1, 9, 9); drive(2, 1'b1, 1, 1); tick();
    drive(0, 1'b1, 0, 15);  drive(1, 1'b0, 0, 0); drive(2, 1'b1, 0, 0); tick();
    repeat (12) tick();

    // Back-to-back random traffic
    repeat (16) begin
      for (int unsigned k = 0; k < 3; k++) drive_rand(k);
      tick();
    end
    repeat (12) tick();

    // Random traffic with bubbles
    repeat (16) begin
      for (int unsigned k = 0; k < 3; k++)
        if ($urandom_range(0, 1) == 1) drive_rand(k);
      tick();
    end
    repeat (12) tick();

    // Reset with operations in flight: everything discarded
    repeat (6) begin
      for (int unsigned k = 0; k < 3; k++) drive_rand(k);
      tick();
    end
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    q2.delete();
    #1;
    chk("rst_mid_lane0", 32'(ov0), 32'd0);
    chk("rst_mid_lane1", 32'(ov1), 32'd0);
    chk("rst_mid_lane2", 32'(ov2), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    for (int unsigned k = 0; k < 3; k++) drive(k, 1'b0, (k == 2) ? 1 : 2, (k == 2) ? 1 : 2);
    tick();
    repeat (12) tick();

    chk("pending_results", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/masked_adder_nbit.md
# masked_adder_nbit

Parametrised, fully pipelined, Boolean-masked ripple-carry adder/subtractor with d shares and W-bit operands, producing a W+1-bit masked result (sum plus carry-out) from HPC2 gadgets. It generalises the fixed 2-bit masked adder to arbitrary width and adds a subtract mode, a valid sideband and a reset-cleared control pipeline. It sits in the masked arithmetic datapath, feeding masked comparison and modular-reduction stages.

## Interface
- `d`, 2: number of shares (masking order d-1), ≥2.
- `W`, 4: operand width in bits, ≥1.
- `clk`  in  1  clock; all registers on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; clears the control pipeline only.
- `in_valid`  in  1  operands and `in_sub` valid this cycle.
- `in_sub`  in  1  0: a+b; 1: a-b (a + ~b + 1). Public, unmasked.
- `in_a`  in  W*d  masked operand a; bit i shares at [i*d +: d].
- `in_b`  in  W*d  masked operand b, same layout.
- `rnd`  in  (2W-1)*d(d-1)/2  fresh randomness, required every cycle.
- `out_valid`  out  1  `out_c` carries a result.
- `out_c`  out  (W+1)*d  masked result; bits 0..W-1 sum, bit W carry-out.

## Operation
- Per bit i: p_i = a_i ^ b'_i (share-wise), g_i = a_i & b'_i (HPC2); b'_i = b_i with share 0 inverted when sub=1.
- Carry: c_0 = sub (public). c_{i+1} = g_i ^ (p_i & c_i); g and p&c are mutually exclusive, so XOR replaces OR.
- Bit 0: p_0 & c_0 is share-wise AND with public constant, no gadget; bits 1..W-1 each use one HPC2 for p_i & c_i.
- Gadget count 2W-1; each takes its own d(d-1)/2 slice of `rnd`: g_i gadgets slices 0..W-1 in bit order, product gadgets slices W..2W-2 for bits 1..W-1.
- Sum s_i = p_i ^ c_i share-wise; s_W = c_W.
- Sub mode: bit W = 1 iff a ≥ b (no borrow); sum = (a-b) mod 2^W.
- Shares never recombined internally; no share-crossing XOR outside gadgets.
- `in_sub` and `in_valid` travel in delay lines aligned with the data; `in_sub` delay taps feed each bit's b' inversion.
- No backpressure, no stall: one new operation may enter every cycle.

## Timing
- Latency L = 2W+2 cycles: `out_valid` rises L cycles after the `in_valid` sample (W=4 → 10, W=1 → 4).
- Input register stage 1 cycle; each carry stage 2 cycles (gadget-wrapper latency); output register 1 cycle.
- p_i, g_i and a_i/b_i delayed by skew registers so bit i meets c_i at stage 1+2i.
- Throughput 1 result/cycle; consecutive inputs produce consecutive outputs, order preserved.
- Reset: `out_valid` = 0 and whole valid pipeline = 0 immediately (async assert); `out_c` has no reset (unreset gadget registers), don't-care while `out_valid`=0.
- Reset mid-operation: all in-flight results discarded; first `in_valid` after `rst_n` deasserts returns after exactly L cycles.
- `rnd` sampled every cycle regardless of `in_valid`; reuse of randomness is a caller error, not detected.

## Structure
- Shared package `masked_pkg`: function `hpc2_nrnd(d)` = d*(d-1)/2, localparam helpers for latency L(W) and rnd width.
- Sub-module `masked_carry_stage`: one bit slice (HPC2 product gadget, XOR with g_i, skew registers for p_i); top level instantiates W-1 of them plus the bit-0 slice, g-gadget row and valid/sub delay lines.
- Reuse existing MSKreg, MSKxor, MSKand_HPC2; no new gadgets.

## Test plan
- d=2, W=4, add 3+5 → after 10 cycles `out_valid`=1, recombined result 8, carry 0.
- d=2, W=4, add 15+1 → sum 0, carry 1; add 15+15 → sum 14, carry 1.
- d=3, W=4, sub 7-5 → sum 2, carry 1; sub 5-7 → sum 14, carry 0; sub 9-9 → sum 0, carry 1.
- Back-to-back: 16 consecutive random (a,b,sub) with random shares, `in_valid` every cycle → 16 consecutive correct outputs, no gaps, in order; repeat with gaps → gaps reproduced.
- Reset after 3 of 6 in-flight ops → `out_valid` 0 throughout and after reset; new op 2+2 returns 4 after exactly L cycles.
- W=1, d=2: 1+1 → sum 0, carry 1 after 4 cycles; sub 0-1 → sum 1, carry 0.
